// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit_if
// Brief    : MEM-stage request bus plus word-memory bus of the sub-word sequencer
// Revision : 1.0
// ============================================================================
interface mem_access_unit_if;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic        misalign;
    logic        busy;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_read_data;

    modport master (
        output req, we, size, sign_ext, addr, wdata, mem_read_data,
        input  rdata, ack, misalign, busy, mem_address, mem_write_data,
               mem_read, mem_write
    );

    modport slave (
        input  req, we, size, sign_ext, addr, wdata, mem_read_data,
        output rdata, ack, misalign, busy, mem_address, mem_write_data,
               mem_read, mem_write
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Brief    : Byte/half/word load-store sequencer with read-modify-write stores
// Revision : 1.0
// ============================================================================
module mem_access_unit (
    input  wire logic         clk,
    input  wire logic         reset,
    mem_access_unit_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_RMW_RD = 3'd2,
        S_STORE  = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    localparam logic [1:0] c_SZ_BYTE = 2'b00;
    localparam logic [1:0] c_SZ_HALF = 2'b01;
    localparam logic [1:0] c_SZ_WORD = 2'b10;

    state_t      state_q, state_d;
    logic [1:0]  size_q, size_d;
    logic        sign_q, sign_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wbuf_q, wbuf_d;
    logic        mis_q, mis_d;
    logic [31:0] rdata_q, rdata_d;

    logic        w_misalign;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_val;
    logic [31:0] w_merged;

    always_comb begin
        w_misalign = 1'b0;
        case (bus.size)
            c_SZ_HALF: w_misalign = bus.addr[0];
            c_SZ_WORD: w_misalign = (bus.addr[1:0] != 2'b00);
            c_SZ_BYTE: w_misalign = 1'b0;
            default:   w_misalign = 1'b1;
        endcase
    end

    // Lane extraction and merge work on the latched address offset.
    assign w_byte = bus.mem_read_data[{addr_q[1:0], 3'b000} +: 8];
    assign w_half = addr_q[1] ? bus.mem_read_data[31:16] : bus.mem_read_data[15:0];

    always_comb begin
        w_load_val = bus.mem_read_data;
        case (size_q)
            c_SZ_BYTE: w_load_val = {{24{sign_q & w_byte[7]}}, w_byte};
            c_SZ_HALF: w_load_val = {{16{sign_q & w_half[15]}}, w_half};
            default:   w_load_val = bus.mem_read_data;
        endcase
    end

    always_comb begin
        w_merged = bus.mem_read_data;
        if (size_q == c_SZ_BYTE) begin
            w_merged[{addr_q[1:0], 3'b000} +: 8] = wbuf_q[7:0];
        end else begin
            w_merged[{addr_q[1], 4'b0000} +: 16] = wbuf_q[15:0];
        end
    end

    always_comb begin
        state_d = state_q;
        size_d  = size_q;
        sign_d  = sign_q;
        addr_d  = addr_q;
        wbuf_d  = wbuf_q;
        mis_d   = mis_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    size_d = bus.size;
                    sign_d = bus.sign_ext;
                    addr_d = bus.addr;
                    wbuf_d = bus.wdata;
                    mis_d  = w_misalign;
                    if (w_misalign) begin
                        state_d = S_RESP;
                    end else if (!bus.we) begin
                        state_d = S_LOAD;
                    end else if (bus.size == c_SZ_WORD) begin
                        state_d = S_STORE;
                    end else begin
                        state_d = S_RMW_RD;
                    end
                end
            end
            S_LOAD: begin
                rdata_d = w_load_val;
                state_d = S_RESP;
            end
            S_RMW_RD: begin
                wbuf_d  = w_merged;
                state_d = S_STORE;
            end
            S_STORE: state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            size_q  <= 2'b00;
            sign_q  <= 1'b0;
            addr_q  <= 32'd0;
            wbuf_q  <= 32'd0;
            mis_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            size_q  <= size_d;
            sign_q  <= sign_d;
            addr_q  <= addr_d;
            wbuf_q  <= wbuf_d;
            mis_q   <= mis_d;
            rdata_q <= rdata_d;
        end
    end

    // The write strobe is gated by reset so an abandoned store never commits.
    assign bus.mem_write      = (state_q == S_STORE) & ~reset;
    assign bus.mem_read       = (state_q == S_LOAD) | (state_q == S_RMW_RD);
    assign bus.mem_address    = {addr_q[31:2], 2'b00};
    assign bus.mem_write_data = wbuf_q;
    assign bus.ack            = (state_q == S_RESP);
    assign bus.misalign       = (state_q == S_RESP) & mis_q;
    assign bus.busy           = (state_q != S_IDLE);
    assign bus.rdata          = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Brief    : Directed self-checking bench for mem_access_unit with a word memory
// Revision : 1.0
// ============================================================================
module tb_mem_access_unit;

    logic        clk;
    logic        reset;
    logic [31:0] mem [0:63];
    int          vec;
    int          errs;

    mem_access_unit_if bus ();

    mem_access_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.mem_read_data = mem[bus.mem_address[7:2]];

    always @(posedge clk) begin
        if (bus.mem_write) mem[bus.mem_address[7:2]] <= bus.mem_write_data;
    end

    task automatic issue(input logic w, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] d,
                         output int lat, output int nrd, output int nwr,
                         output int ovl, output logic mis);
        lat = -1; nrd = 0; nwr = 0; ovl = 0; mis = 1'b0;
        @(negedge clk);
        bus.req = 1'b1; bus.we = w; bus.size = sz; bus.sign_ext = sx;
        bus.addr = a; bus.wdata = d;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (bus.mem_read) nrd++;
            if (bus.mem_write) nwr++;
            if (bus.mem_read && bus.mem_write) ovl++;
            if (bus.ack) begin
                lat = c;
                mis = bus.misalign;
                break;
            end
        end
        bus.req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vec++;
        if ({bus.ack, bus.misalign, bus.busy, bus.mem_read, bus.mem_write} !== 5'b0) begin
            errs++;
            $display("FAIL reset_flags got %b want 00000",
                     {bus.ack, bus.misalign, bus.busy, bus.mem_read, bus.mem_write});
        end
        vec++;
        if ({bus.rdata, bus.mem_address, bus.mem_write_data} !== 96'd0) begin
            errs++;
            $display("FAIL reset_data got rdata=%h addr=%h wd=%h want 0",
                     bus.rdata, bus.mem_address, bus.mem_write_data);
        end
        reset = 1'b0;
    endtask

    task automatic test_word_load;
        int lat, nrd, nwr, ovl; logic mis;
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, nrd, nwr, ovl, mis);
        vec++;
        if (lat !== 2) begin errs++; $display("FAIL lw_latency got %0d want 2", lat); end
        vec++;
        if (bus.rdata !== 32'h8899AABB) begin errs++; $display("FAIL lw_rdata got %h want 8899aabb", bus.rdata); end
        vec++;
        if ({nrd, nwr, 31'd0, mis} !== {32'd1, 32'd0, 32'd0}) begin
            errs++; $display("FAIL lw_strobes got rd=%0d wr=%0d mis=%b want rd=1 wr=0 mis=0", nrd, nwr, mis);
        end
    endtask

    task automatic test_subword_loads;
        int lat, nrd, nwr, ovl; logic mis;
        logic [1:0]  sz  [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
        logic        sx  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] ad  [4] = '{32'h13, 32'h13, 32'h10, 32'h12};
        logic [31:0] exp [4] = '{32'hFFFFFF88, 32'h00000088, 32'hFFFFAABB, 32'h00008899};
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, sz[i], sx[i], ad[i], 32'h0, lat, nrd, nwr, ovl, mis);
            vec++;
            if (bus.rdata !== exp[i] || lat !== 2) begin
                errs++;
                $display("FAIL subword_load_%0d got rdata=%h lat=%0d want %h lat=2", i, bus.rdata, lat, exp[i]);
            end
        end
    endtask

    task automatic test_byte_store;
        int lat, nrd, nwr, ovl; logic mis;
        issue(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000CC, lat, nrd, nwr, ovl, mis);
        vec++;
        if (lat !== 3) begin errs++; $display("FAIL sb_latency got %0d want 3", lat); end
        vec++;
        if (nrd !== 1 || nwr !== 1 || ovl !== 0 || mis !== 1'b0) begin
            errs++; $display("FAIL sb_strobes got rd=%0d wr=%0d ovl=%0d mis=%b want 1 1 0 0", nrd, nwr, ovl, mis);
        end
        vec++;
        if (mem[4] !== 32'h8899CCBB) begin errs++; $display("FAIL sb_mem got %h want 8899ccbb", mem[4]); end
        vec++;
        if (bus.rdata !== 32'h00008899) begin errs++; $display("FAIL sb_rdata_hold got %h want 00008899", bus.rdata); end
    endtask

    task automatic test_half_word_store;
        int lat, nrd, nwr, ovl; logic mis;
        issue(1'b1, 2'b01, 1'b0, 32'h12, 32'h00001234, lat, nrd, nwr, ovl, mis);
        vec++;
        if (mem[4] !== 32'h1234CCBB || lat !== 3) begin
            errs++; $display("FAIL sh_mem got %h lat=%0d want 1234ccbb lat=3", mem[4], lat);
        end
        issue(1'b1, 2'b10, 1'b0, 32'h14, 32'hDEADBEEF, lat, nrd, nwr, ovl, mis);
        vec++;
        if (mem[5] !== 32'hDEADBEEF) begin errs++; $display("FAIL sw_mem got %h want deadbeef", mem[5]); end
        vec++;
        if (lat !== 2 || nrd !== 0 || nwr !== 1) begin
            errs++; $display("FAIL sw_timing got lat=%0d rd=%0d wr=%0d want 2 0 1", lat, nrd, nwr);
        end
        vec++;
        if (mem[4] !== 32'h1234CCBB) begin errs++; $display("FAIL sw_neighbour got %h want 1234ccbb", mem[4]); end
    endtask

    task automatic test_faults;
        int lat, nrd, nwr, ovl; logic mis;
        logic        w   [3] = '{1'b0, 1'b0, 1'b1};
        logic [1:0]  sz  [3] = '{2'b10, 2'b11, 2'b01};
        logic [31:0] ad  [3] = '{32'h11, 32'h10, 32'h13};
        for (int i = 0; i < 3; i++) begin
            issue(w[i], sz[i], 1'b1, ad[i], 32'h0000FFFF, lat, nrd, nwr, ovl, mis);
            vec++;
            if (lat !== 1 || mis !== 1'b1 || nrd !== 0 || nwr !== 0) begin
                errs++;
                $display("FAIL fault_%0d got lat=%0d mis=%b rd=%0d wr=%0d want 1 1 0 0", i, lat, mis, nrd, nwr);
            end
            vec++;
            if (bus.rdata !== 32'h00008899 || mem[4] !== 32'h1234CCBB) begin
                errs++;
                $display("FAIL fault_state_%0d got rdata=%h mem=%h want 00008899 1234ccbb", i, bus.rdata, mem[4]);
            end
        end
    endtask

    task automatic test_reset_mid_store;
        logic ack_seen;
        ack_seen = 1'b0;
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'b00; bus.sign_ext = 1'b0;
        bus.addr = 32'h10; bus.wdata = 32'h00000055;
        repeat (2) begin
            @(posedge clk); #1;
        end
        vec++;
        if (bus.mem_write !== 1'b1) begin errs++; $display("FAIL rst_store_reached got mem_write=%b want 1", bus.mem_write); end
        reset = 1'b1;
        bus.req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        vec++;
        if ({bus.ack, bus.misalign, bus.busy, bus.mem_read, bus.mem_write} !== 5'b0 ||
            {bus.rdata, bus.mem_address, bus.mem_write_data} !== 96'd0) begin
            errs++;
            $display("FAIL rst_outputs got flags=%b rdata=%h addr=%h wd=%h want all 0",
                     {bus.ack, bus.misalign, bus.busy, bus.mem_read, bus.mem_write},
                     bus.rdata, bus.mem_address, bus.mem_write_data);
        end
        repeat (4) begin
            @(posedge clk); #1;
            if (bus.ack) ack_seen = 1'b1;
        end
        vec++;
        if (ack_seen !== 1'b0) begin errs++; $display("FAIL rst_no_ack got %b want 0", ack_seen); end
        vec++;
        if (mem[4] !== 32'h1234CCBB) begin errs++; $display("FAIL rst_mem got %h want 1234ccbb", mem[4]); end
    endtask

    initial begin
        vec = 0; errs = 0;
        reset = 1'b1;
        bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'b00; bus.sign_ext = 1'b0;
        bus.addr = 32'd0; bus.wdata = 32'd0;
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        mem[4] = 32'h8899AABB;

        test_reset;
        test_word_load;
        test_subword_loads;
        test_byte_store;
        test_half_word_store;
        test_faults;
        test_reset_mid_store;

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
`default_nettype wire
